// File: rtl/helen_onchip_logger_if.sv
`default_nettype none
// ============================================================================
// helen_onchip_logger_if : byte sink + Avalon-MM RAM write bus of the logger
// Revision : 1.0
// ============================================================================
interface helen_onchip_logger_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_eop;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [3:0]            mem_byteenable;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [31:0]           mem_writedata;
  logic                  mem_clken;

  // Logger side: consumes the byte stream, masters the RAM port.
  modport master (
    input  in_data, in_valid, in_eop,
    output in_ready,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken
  );

  // Environment side: byte source plus the RAM slave.
  modport slave (
    output in_data, in_valid, in_eop,
    input  in_ready,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken
  );
endinterface
`default_nettype wire

// File: rtl/helen_onchip_logger.sv
`default_nettype none
// ============================================================================
// helen_onchip_logger : packs a byte stream into 32-bit words written to RAM
// Revision : 1.0
// ============================================================================
module helen_onchip_logger #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter bit WRAP       = 1'b1
) (
  input  wire                    clk,
  input  wire                    reset_n,
  input  wire                    enable,
  input  wire                    clear,
  helen_onchip_logger_if.master  bus,
  output logic [ADDR_WIDTH-1:0]  wr_ptr,
  output logic [ADDR_WIDTH:0]    word_count,
  output logic                   full,
  output logic                   overflow
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_lane;
  logic [31:0]           r_stage;

  logic                  w_final_strobe;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_issue;
  logic [31:0]           w_word;
  logic [3:0]            w_be;
  logic [ADDR_WIDTH-1:0] w_issue_addr;

  // In one-shot mode the sink is closed while the last word is being written,
  // so no byte can slip into a buffer that is about to be declared full.
  assign w_final_strobe = !WRAP && bus.mem_write && (wr_ptr == c_LAST_ADDR);
  assign w_ready        = (r_state == FILL) && !w_final_strobe;
  assign bus.in_ready   = w_ready;

  assign w_accept = bus.in_valid && w_ready && !clear;
  assign w_issue  = w_accept && ((r_lane == 2'd3) || bus.in_eop);
  assign w_word   = r_stage | ({24'd0, bus.in_data} << {r_lane, 3'b000});

  // A write issued while another is strobing targets the slot after it,
  // because wr_ptr only advances at the end of the strobe cycle.
  assign w_issue_addr = bus.mem_write ? (wr_ptr + c_ADDR_ONE) : wr_ptr;

  always_comb begin
    w_be = 4'b0001;
    case (r_lane)
      2'd1:    w_be = 4'b0011;
      2'd2:    w_be = 4'b0111;
      2'd3:    w_be = 4'b1111;
      default: w_be = 4'b0001;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= IDLE;
      r_lane             <= 2'd0;
      r_stage            <= 32'd0;
      wr_ptr             <= '0;
      word_count         <= '0;
      full               <= 1'b0;
      overflow           <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_byteenable <= 4'd0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_writedata  <= 32'd0;
      bus.mem_clken      <= 1'b0;
    end else begin
      bus.mem_clken      <= 1'b1;
      bus.mem_write      <= w_issue;
      bus.mem_chipselect <= w_issue;
      if (w_issue) begin
        bus.mem_address    <= w_issue_addr;
        bus.mem_writedata  <= w_word;
        bus.mem_byteenable <= w_be;
      end

      if (clear) begin
        r_state    <= IDLE;
        r_lane     <= 2'd0;
        r_stage    <= 32'd0;
        wr_ptr     <= '0;
        word_count <= '0;
        full       <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (bus.mem_write) begin
          wr_ptr <= wr_ptr + c_ADDR_ONE;
          if (word_count != c_DEPTH_CNT)
            word_count <= word_count + c_CNT_ONE;
          // Overwriting a slot of an already-full buffer marks lost data.
          if (WRAP && (word_count == c_DEPTH_CNT))
            overflow <= 1'b1;
          if (!WRAP && (wr_ptr == c_LAST_ADDR))
            full <= 1'b1;
        end

        if (w_accept) begin
          if (w_issue) begin
            r_lane  <= 2'd0;
            r_stage <= 32'd0;
          end else begin
            r_lane  <= r_lane + 2'd1;
            r_stage <= w_word;
          end
        end

        case (r_state)
          IDLE: begin
            if (enable && !full)
              r_state <= FILL;
          end
          FILL: begin
            if (w_final_strobe)
              r_state <= STOP;
            else if (!enable)
              r_state <= IDLE;
          end
          STOP: r_state <= STOP;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_helen_onchip_logger.sv
`default_nettype none
// Directed bench: default build plus DEPTH=4 wrap and one-shot builds, all fed
// the same byte stream; each step checks the build(s) it is meant for.
module tb_helen_onchip_logger;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_eop = 1'b0;

  logic [11:0] wr_ptr0;
  logic [12:0] cnt0;
  logic        full0, ovf0;
  logic [1:0]  wr_ptrw, wr_ptrf;
  logic [2:0]  cntw, cntf;
  logic        fullw, ovfw, fullf, ovff;

  int errors = 0;
  int checks = 0;
  int nwr0 = 0, nwrw = 0, nwrf = 0;
  int s0, sw, sf;

  helen_onchip_logger_if #(.ADDR_WIDTH(12)) b0 ();
  helen_onchip_logger_if #(.ADDR_WIDTH(2))  bw ();
  helen_onchip_logger_if #(.ADDR_WIDTH(2))  bf ();

  assign b0.in_data = in_data;  assign b0.in_valid = in_valid;  assign b0.in_eop = in_eop;
  assign bw.in_data = in_data;  assign bw.in_valid = in_valid;  assign bw.in_eop = in_eop;
  assign bf.in_data = in_data;  assign bf.in_valid = in_valid;  assign bf.in_eop = in_eop;

  helen_onchip_logger #(.ADDR_WIDTH(12), .DEPTH(4096), .WRAP(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(b0),
    .wr_ptr(wr_ptr0), .word_count(cnt0), .full(full0), .overflow(ovf0));
  helen_onchip_logger #(.ADDR_WIDTH(2), .DEPTH(4), .WRAP(1'b1)) dutw (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(bw),
    .wr_ptr(wr_ptrw), .word_count(cntw), .full(fullw), .overflow(ovfw));
  helen_onchip_logger #(.ADDR_WIDTH(2), .DEPTH(4), .WRAP(1'b0)) dutf (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(bf),
    .wr_ptr(wr_ptrf), .word_count(cntf), .full(fullf), .overflow(ovff));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b0.mem_write) nwr0++;
    if (bw.mem_write) nwrw++;
    if (bf.mem_write) nwrf++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic eop);
    in_data  = b;
    in_valid = 1'b1;
    in_eop   = eop;
    cyc();
    in_eop   = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc();
    check("rst_in_ready", b0.in_ready, 0);
    check("rst_clken", b0.mem_clken, 0);
    check("rst_write", b0.mem_write, 0);
    check("rst_wr_ptr", wr_ptr0, 0);
    check("rst_count", cnt0, 0);
    check("rst_flags", {full0, ovf0, fullf, ovfw}, 0);
    reset_n = 1'b1;
    cyc();
    check("clken_after_rst", b0.mem_clken, 1);
    check("idle_not_ready", b0.in_ready, 0);
    enable = 1'b1;
    cyc();
    check("fill_ready", b0.in_ready, 1);

    // Full word
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    check("w1_write", b0.mem_write, 1);
    check("w1_cs", b0.mem_chipselect, 1);
    check("w1_addr", b0.mem_address, 0);
    check("w1_data", b0.mem_writedata, 32'h44332211);
    check("w1_be", b0.mem_byteenable, 4'b1111);
    in_valid = 1'b0;
    cyc();
    check("w1_write_done", b0.mem_write, 0);
    check("w1_wr_ptr", wr_ptr0, 1);
    check("w1_count", cnt0, 1);

    // Partial flush on eop, then back-to-back eop writes
    clear = 1'b1; cyc(); clear = 1'b0;
    check("clr_wr_ptr", wr_ptr0, 0);
    check("clr_count", cnt0, 0);
    check("clr_idle", b0.in_ready, 0);
    cyc();
    send(8'hAA, 0); send(8'hBB, 1);
    check("eop_write", b0.mem_write, 1);
    check("eop_addr", b0.mem_address, 0);
    check("eop_data", b0.mem_writedata, 32'h0000BBAA);
    check("eop_be", b0.mem_byteenable, 4'b0011);
    send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 0); send(8'hFF, 0);
    check("cc_addr", b0.mem_address, 1);
    check("cc_data", b0.mem_writedata, 32'hFFEEDDCC);
    send(8'h5A, 1);
    check("b2b_a_addr", b0.mem_address, 2);
    check("b2b_a_be", b0.mem_byteenable, 4'b0001);
    send(8'h5B, 1);
    check("b2b_b_write", b0.mem_write, 1);
    check("b2b_b_addr", b0.mem_address, 3);
    check("b2b_b_data", b0.mem_writedata, 32'h0000005B);
    in_valid = 1'b0;
    cyc();
    check("b2b_wr_ptr", wr_ptr0, 4);

    // Continuous stream: 20 bytes, one write per four
    clear = 1'b1; cyc(); clear = 1'b0;
    cyc();
    s0 = nwr0; sw = nwrw; sf = nwrf;
    for (int i = 0; i < 20; i++) begin
      check("stream_ready", b0.in_ready, 1);
      send(8'(i + 1), 0);
      check("stream_write", b0.mem_write, (i % 4) == 3);
      if ((i % 4) == 3) begin
        check("stream_addr", b0.mem_address, i / 4);
        check("wrap_addr", bw.mem_address, (i / 4) % 4);
      end
      if (i == 3)  check("stream_data", b0.mem_writedata, 32'h04030201);
      if (i == 15) check("full_last_addr", bf.mem_address, 3);
      if (i == 16) begin
        check("full_set", fullf, 1);
        check("full_not_ready", bf.in_ready, 0);
        check("full_wr_ptr", wr_ptrf, 0);
        check("wrap_ovf_not_yet", ovfw, 0);
        check("wrap_count4", cntw, 4);
      end
    end
    in_valid = 1'b0;
    cyc();
    check("stream_nwr", nwr0 - s0, 5);
    check("wrap_nwr", nwrw - sw, 5);
    check("full_nwr", nwrf - sf, 4);
    check("wrap_ovf", ovfw, 1);
    check("wrap_count_sat", cntw, 4);
    check("wrap_wr_ptr", wr_ptrw, 1);
    check("stream_count", cnt0, 5);
    check("stream_no_ovf", ovf0, 0);
    check("full_count", cntf, 4);

    // Clear releases the one-shot build
    clear = 1'b1; cyc(); clear = 1'b0;
    check("fclr_full", fullf, 0);
    check("fclr_wr_ptr", wr_ptrf, 0);
    check("fclr_idle", bf.in_ready, 0);
    cyc();
    check("fclr_refill", bf.in_ready, 1);

    // Clear drops the partial word and the byte presented with it
    send(8'h01, 0); send(8'h02, 0);
    in_data = 8'h03; in_valid = 1'b1; clear = 1'b1;
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_no_write", b0.mem_write, 0);
    cyc();
    check("clr_no_write2", b0.mem_write, 0);
    check("clr_count0", cnt0, 0);
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
    check("post_clr_addr", b0.mem_address, 0);
    check("post_clr_data", b0.mem_writedata, 32'hA4A3A2A1);
    check("post_clr_be", b0.mem_byteenable, 4'b1111);
    in_valid = 1'b0;
    cyc();

    // Enable drop mid-word keeps the staged bytes
    send(8'hB1, 0); send(8'hB2, 0);
    in_valid = 1'b0; enable = 1'b0;
    cyc();
    check("dis_not_ready", b0.in_ready, 0);
    cyc();
    check("dis_no_write", b0.mem_write, 0);
    enable = 1'b1;
    cyc();
    check("reen_ready", b0.in_ready, 1);
    send(8'hB3, 0); send(8'hB4, 0);
    check("resume_write", b0.mem_write, 1);
    check("resume_addr", b0.mem_address, 1);
    check("resume_data", b0.mem_writedata, 32'hB4B3B2B1);

    // Asynchronous reset during a write strobe
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_write", b0.mem_write, 0);
    check("arst_cs", b0.mem_chipselect, 0);
    check("arst_clken", b0.mem_clken, 0);
    check("arst_wr_ptr", wr_ptr0, 0);
    check("arst_ready", b0.in_ready, 0);
    cyc();
    reset_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
